// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if -- bundle of the decode-side request, memory-side and write-back
// signals of the memory access unit.
//
// Signal summary:
//   ld_req, st_req      decoded load / store present
//   addr, st_data       data-memory address and store operand
//   ld_dst              destination register code of the load
//   mem_req, mem_we     memory request and write strobe
//   mem_addr, mem_wdata registered memory address and write data
//   mem_rdata, mem_ack  memory read data and completion
//   load_data, load_en, load_dst  register-file write-back
//   stall               holds fetch/decode and the PC
//   err                 sticky timeout flag
//
// Modports: slave = the unit itself, master = pipeline/memory side driving it.
interface mem_access_unit_if;
    logic       ld_req;
    logic       st_req;
    logic [7:0] addr;
    logic [7:0] st_data;
    logic [3:0] ld_dst;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] load_data;
    logic       load_en;
    logic [3:0] load_dst;
    logic       stall;
    logic       err;

    modport slave (
        input  ld_req, st_req, addr, st_data, ld_dst, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, load_data, load_en, load_dst, stall, err
    );

    modport master (
        output ld_req, st_req, addr, st_data, ld_dst, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, load_data, load_en, load_dst, stall, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit -- sequences one load or store at a time against a data memory with a
// request/acknowledge handshake, writes load results back to the register file and stalls
// the front end while a transaction is outstanding.
//
// Ports:
//   clk     input   system clock, all state changes on posedge
//   start   input   asynchronous active-high reset
//   io_bus  slave   request, memory and write-back signals (see mem_access_unit_if)
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a memory wait after 15 cycles
// without acknowledge and raise the sticky err flag. Without it the unit waits forever
// and err is tied low.
module mem_access_unit (
    input  logic                     clk,
    input  logic                     start,
    mem_access_unit_if.slave         io_bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_DONE = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic [7:0] r_load_data;
    logic [3:0] r_load_dst;
    logic       w_waiting;
    logic       w_accept;
    logic       w_timeout;

    assign w_waiting = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
    assign w_accept  = (r_state == ST_IDLE) && (io_bus.st_req || io_bus.ld_req);

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [3:0] r_tmo_cnt;
    logic       r_err;

    // Fires on the 15th consecutive unacknowledged wait cycle; the counter reaches 15 at
    // the same edge the state is forced out of the wait.
    assign w_timeout = w_waiting && !io_bus.mem_ack && (r_tmo_cnt == 4'd14);

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            r_tmo_cnt <= 4'd0;
            r_err     <= 1'b0;
        end else begin
            // Waits are only entered from IDLE, so clearing there clears on entry.
            if (r_state == ST_IDLE) begin
                r_tmo_cnt <= 4'd0;
            end else if (w_waiting && !io_bus.mem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 4'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign io_bus.err = r_err;
`else
    assign w_timeout  = 1'b0;
    assign io_bus.err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Store wins; a concurrent load is still held by the stalled requester.
                if (io_bus.st_req) begin
                    w_state_next = ST_WR_WAIT;
                end else if (io_bus.ld_req) begin
                    w_state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (io_bus.mem_ack || w_timeout) begin
                    w_state_next = ST_RD_DONE;
                end
            end
            ST_WR_WAIT: begin
                if (io_bus.mem_ack || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD_DONE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            r_mem_addr  <= 8'h00;
            r_mem_wdata <= 8'h00;
            r_load_data <= 8'h00;
            r_load_dst  <= 4'h0;
        end else begin
            if (w_accept) begin
                r_mem_addr <= io_bus.addr;
                r_load_dst <= io_bus.ld_dst;
                if (io_bus.st_req) begin
                    r_mem_wdata <= io_bus.st_data;
                end
            end
            if (r_state == ST_RD_WAIT) begin
                if (io_bus.mem_ack) begin
                    r_load_data <= io_bus.mem_rdata;
                end else if (w_timeout) begin
                    r_load_data <= 8'h00;
                end
            end
        end
    end

    // Decoded straight from the state register so the async reset drops them at once.
    assign io_bus.mem_req   = w_waiting;
    assign io_bus.mem_we    = (r_state == ST_WR_WAIT);
    assign io_bus.load_en   = (r_state == ST_RD_DONE);
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.load_data = r_load_data;
    assign io_bus.load_dst  = r_load_dst;

    // Store release happens in the ack cycle itself, hence the combinational mem_ack term.
    assign io_bus.stall = w_accept
                        || (r_state == ST_RD_WAIT)
                        || ((r_state == ST_WR_WAIT) && !io_bus.mem_ack);

endmodule
